four_bit_accumulator: RTL and testbench

Sequential stage directly downstream of the four-bit behavioural adder. It accepts operand pairs over a valid/ready handshake and adds each pair into a 5-bit sum (carry plus four sum bits). That sum is added into a running ACC_W-bit accumulator, and each result is presented over an output valid/ready handshake. It also counts accepted operations and flags accumulator overflow with a sticky bit.

---
 rtl/four_bit_accumulator.sv | 114 +++++++++++
 tb/tb_four_bit_accumulator.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_accumulator.sv
// Handshaked accumulator: adds each 4-bit x/y pair into a running ACC_W-bit sum, counts operations, flags overflow.
// Build option ACC_SATURATE_EN: clamp the accumulator to all ones on overflow instead of wrapping.
module four_bit_accumulator #(
   parameter int ACC_W = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       x,
   input  logic [3:0]       y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic [1:0]       dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on valid,
   // and a source holding valid while ready=0 is simply waited on.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       xr_q, xr_d;
   logic [3:0]       yr_q, yr_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic [4:0]       sum5;
   logic [ACC_W:0]   acc_sum;

   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // rst_n gates in_ready so nothing is offered while reset is held
   assign in_ready    = rst_n && !clr && (state_q == S_IDLE);
   assign out_valid   = (state_q == S_HOLD);
   assign acc         = acc_q;
   assign cnt         = cnt_q;
   assign ovf         = ovf_q;
   assign dbg_state_o = state_q;

   assign sum5    = {1'b0, xr_q} + {1'b0, yr_q};
   assign acc_sum = {1'b0, acc_q} + {{(ACC_W-4){1'b0}}, sum5};

   always_comb begin
      state_d = state_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               state_d = S_ADD;
               xr_d    = x;
               yr_d    = y;
            end
         end
         S_ADD: begin
            state_d = S_HOLD;
            if (acc_sum[ACC_W]) begin
               ovf_d = 1'b1;
`ifdef ACC_SATURATE_EN
               acc_d = ACC_MAX;
`else
               acc_d = acc_sum[ACC_W-1:0];
`endif
            end else begin
               acc_d = acc_sum[ACC_W-1:0];
            end
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         end
         S_HOLD: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (clr) begin
         state_d = S_IDLE;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         xr_q    <= '0;
         yr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_four_bit_accumulator.sv
// Randomized self-checking bench for four_bit_accumulator against an integer reference model.
module tb_four_bit_accumulator;
   localparam int ACC_W = 8;
   localparam int CNT_W = 4;
   localparam int EW    = 1 + CNT_W + ACC_W;
   localparam int unsigned ACC_LIM = (1 << ACC_W) - 1;
   localparam int unsigned CNT_LIM = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       x;
   logic [3:0]       y;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic [1:0]       dbg_state_o;

   four_bit_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .out_valid(out_valid), .out_ready(out_ready),
      .acc(acc), .cnt(cnt), .ovf(ovf), .dbg_state_o(dbg_state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fails  = 0;

   // reference model
   int unsigned acc_m;
   int unsigned cnt_m;
   logic        ovf_m;
   logic [EW-1:0] exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      acc_m = 0;
      cnt_m = 0;
      ovf_m = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_add(input logic [3:0] a, input logic [3:0] b);
      int unsigned t;
      t = acc_m + a + b;
      if (t > ACC_LIM) begin
         ovf_m = 1'b1;
`ifdef ACC_SATURATE_EN
         acc_m = ACC_LIM;
`else
         acc_m = t - (ACC_LIM + 1);
`endif
      end else begin
         acc_m = t;
      end
      if (cnt_m < CNT_LIM) cnt_m++;
      exp_q.push_back({ovf_m, CNT_W'(cnt_m), ACC_W'(acc_m)});
   endtask

   // driver: offer a pair, wait (bounded) for acceptance, return at the negedge of the ADD cycle
   task automatic accept_op(input logic [3:0] a, input logic [3:0] b);
      int guard;
      x = a;
      y = b;
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20) check_eq("in_ready_timeout", 32'(in_ready), 32'd1);
      model_add(a, b);
      @(negedge clk);
      in_valid = 1'b0;
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      check_eq("add_in_ready", 32'(in_ready), 32'd0);
      check_eq("add_out_valid", 32'(out_valid), 32'd0);
   endtask

   // driver: from ADD, observe the result, apply `stall` cycles of backpressure, then consume it
   task automatic finish_op(input int stall);
      logic [EW-1:0] e;
      out_ready = (stall == 0);
      @(negedge clk);
      check_eq("hold_out_valid", 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         check_eq("exp_q_empty", 32'd0, 32'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check_eq("acc", 32'(acc), 32'(e[ACC_W-1:0]));
      check_eq("cnt", 32'(cnt), 32'(e[ACC_W +: CNT_W]));
      check_eq("ovf", 32'(ovf), 32'(e[EW-1]));
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         check_eq("stall_out_valid", 32'(out_valid), 32'd1);
         check_eq("stall_in_ready", 32'(in_ready), 32'd0);
         check_eq("stall_acc", 32'(acc), 32'(e[ACC_W-1:0]));
      end
      out_ready = 1'b1;
      if (stall > 0) @(negedge clk);
      else ;
      if (stall > 0) begin
         out_ready = 1'b0;
      end
      if (stall == 0) begin
         @(negedge clk);
         out_ready = 1'b0;
      end
      check_eq("idle_out_valid", 32'(out_valid), 32'd0);
      check_eq("idle_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int stall);
      accept_op(a, b);
      finish_op(stall);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      #1;
      check_eq("clr_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      model_clear();
      #1;
      check_eq("clr_acc", 32'(acc), 32'd0);
      check_eq("clr_cnt", 32'(cnt), 32'd0);
      check_eq("clr_ovf", 32'(ovf), 32'd0);
      check_eq("clr_idle", 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
      model_clear();
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_acc", 32'(acc), 32'd0);
      check_eq("rst_cnt", 32'(cnt), 32'd0);
      check_eq("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // single op straight after reset
      do_op(4'hF, 4'h1, 0);
      check_eq("single_acc", 32'(acc), 32'h10);

      // backpressure
      do_op(4'h2, 4'h3, 5);
      check_eq("bp_acc", 32'(acc), 32'h15);

      // back-to-back from a cleared accumulator
      do_clr();
      do_op(4'd3, 4'd4, 0);
      check_eq("b2b_acc0", 32'(acc), 32'd7);
      do_op(4'd9, 4'd9, 0);
      check_eq("b2b_acc1", 32'(acc), 32'd25);
      do_op(4'd15, 4'd15, 0);
      check_eq("b2b_acc2", 32'(acc), 32'd55);
      check_eq("b2b_cnt", 32'(cnt), 32'd3);

      // overflow from 0xF0
      do_clr();
      for (int i = 0; i < 8; i++) do_op(4'd15, 4'd15, 0);
      check_eq("pre_ovf_acc", 32'(acc), 32'hF0);
      do_op(4'd15, 4'd15, 1);
`ifdef ACC_SATURATE_EN
      check_eq("ovf_acc", 32'(acc), 32'hFF);
`else
      check_eq("ovf_acc", 32'(acc), 32'h0E);
`endif
      check_eq("ovf_flag", 32'(ovf), 32'd1);
      do_op(4'd1, 4'd0, 0);
      check_eq("ovf_sticky", 32'(ovf), 32'd1);

      // clr in HOLD with out_ready: result is discarded
      accept_op(4'd5, 4'd6);
      @(negedge clk);
      check_eq("clrhold_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      do_clr();
      out_ready = 1'b0;
      check_eq("clrhold_out_valid_after", 32'(out_valid), 32'd0);

      // clr with in_valid in IDLE: operand not accepted
      in_valid = 1'b1; x = 4'd7; y = 4'd7;
      do_clr();
      in_valid = 1'b0;
      @(negedge clk);
      check_eq("clr_idle_no_accept", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq("clr_idle_no_result", 32'(out_valid), 32'd0);
      check_eq("clr_idle_acc", 32'(acc), 32'd0);

      // random traffic, long enough to saturate the counter
      for (int i = 0; i < 30; i++) begin
         do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
      check_eq("cnt_saturated", 32'(cnt), 32'(CNT_LIM));

      // asynchronous reset during ADD
      accept_op(4'd9, 4'd8);
      #3;
      rst_n = 1'b0;
      #1;
      check_eq("async_in_ready", 32'(in_ready), 32'd0);
      check_eq("async_out_valid", 32'(out_valid), 32'd0);
      check_eq("async_acc", 32'(acc), 32'd0);
      check_eq("async_cnt", 32'(cnt), 32'd0);
      check_eq("async_ovf", 32'(ovf), 32'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(4'd1, 4'd2, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end
endmodule
